// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle arithmetic blocks.
package multi_cycle_adder_pkg;

  // FSM state encodings. Future multi-cycle arithmetic blocks reuse this encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of chunk steps needed to cover a full operand.
  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of a counter that indexes n chunks. It is never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_cycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit. Each cell's carry feeds the next bit up.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic p;
    assign p      = x[i] ^ y[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & p);
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder that adds CHUNK bits per clock with a registered carry between chunks.
// It uses a start/busy/done handshake. WIDTH must be a multiple of CHUNK.
module multi_cycle_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);

  // The operands and the result are held as chunk-indexed arrays.
  // The active slice is then simply [cnt_q].
  logic [N-1:0][CHUNK-1:0] a_q, a_d;
  logic [N-1:0][CHUNK-1:0] b_q, b_d;
  logic [N-1:0][CHUNK-1:0] sum_q, sum_d;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic             last;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_q[cnt_q]),
    .y  (b_q[cnt_q]),
    .ci (carry_q),
    .s  (ch_s),
    .co (ch_co)
  );

  assign last = (cnt_q == CW'(N - 1));

  // Next-state logic: accept in IDLE/DONE, step one chunk per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = ch_s;
        carry_d      = ch_co;
        cnt_d        = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          cout_d  = ch_co;
          // Overflow occurs when the operands share a sign and the result's sign differs from it.
          ovf_d   = (a_q[N-1][CHUNK-1] == b_q[N-1][CHUNK-1]) &&
                    (ch_s[CHUNK-1] != a_q[N-1][CHUNK-1]);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register. Reset clears everything, which aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder. The main instance uses CHUNK=4.
// Side instances use CHUNK=16 and CHUNK=1 to check latency scaling.
module tb_multi_cycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out, ovf;
  logic [15:0] sum;

  logic        start2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        c2 = 1'b0;
  logic        w_busy, w_done, w_cout, w_ovf;
  logic [15:0] w_sum;
  logic        o_busy, o_done, o_cout, o_ovf;
  logic [15:0] o_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf));

  multi_cycle_adder #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c2),
    .busy(w_busy), .done(w_done), .sum(w_sum), .c_out(w_cout), .ovf(w_ovf));

  multi_cycle_adder #(.WIDTH(16), .CHUNK(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c2),
    .busy(o_busy), .done(o_done), .sum(o_sum), .c_out(o_cout), .ovf(o_ovf));

  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: {ovf, c_out, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int unsigned u;
    int          s;
    logic        ov;
    u  = int'(x) + int'(y) + int'(ci);
    s  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    ov = (s > 32767) || (s < -32768);
    return {ov, u[16], u[15:0]};
  endfunction

  // Issues one op, then scrambles the operand inputs after acceptance.
  // lat counts edges after the accept edge until done is seen; nbusy counts the busy cycles.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        output int lat, output int nbusy);
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lat, nb, k, ndone, first, lw, l1;
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rc;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci, lat, nb);
      chk($sformatf("tbl%0d_sum", i), {16'd0, sum}, {16'd0, tbl[i].s});
      chk($sformatf("tbl%0d_cout", i), {31'd0, c_out}, {31'd0, tbl[i].co});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ov});
      chk($sformatf("tbl%0d_lat", i), lat, 32'd4);
      chk($sformatf("tbl%0d_busy", i), nb, 32'd4);
    end

    // Results hold after done
    repeat (3) @(negedge clk);
    chk("hold_sum", {16'd0, sum}, 32'h0000FFFF);
    chk("hold_cout", {31'd0, c_out}, 32'd1);

    // A start pulse during RUN is ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ndone = 0; first = -1;
    for (int j = 0; j < 20; j++) begin
      if (j == 1) begin a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; start = 1'b1; end
      if (j == 2) start = 1'b0;
      if (done) begin ndone++; if (first < 0) first = j; end
      @(negedge clk);
    end
    chk("ign_ndone", ndone, 32'd1);
    chk("ign_lat", first, 32'd4);
    chk("ign_sum", {16'd0, sum}, 32'h00005556);

    // Back-to-back: start is held in the DONE cycle
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, nb);
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("b2b_gap", k, 32'd5);
    chk("b2b_sum", {16'd0, sum}, 32'h00001000);
    chk("b2b_cout", {31'd0, c_out}, 32'd0);

    // Reset mid-op. c_out and ovf are set beforehand so that clearing them is observable.
    run_op(16'h8000, 16'h8000, 1'b0, lat, nb);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_sum", {16'd0, sum}, 32'd0);
    chk("mrst_cout", {31'd0, c_out}, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 10; j++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mrst_nodone", ndone, 32'd0);
    run_op(16'h1111, 16'h2222, 1'b0, lat, nb);
    chk("mrst_after_sum", {16'd0, sum}, 32'h00003333);
    chk("mrst_after_lat", lat, 32'd4);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      m = model(ra, rb, rc);
      run_op(ra, rb, rc, lat, nb);
      chk($sformatf("rnd%0d %h+%h+%0d", i, ra, rb, rc), {14'd0, ovf, c_out, sum}, {14'd0, m});
    end

    // CHUNK=16 and CHUNK=1 builds
    @(negedge clk);
    a2 = 16'hABCD; b2 = 16'h5433; c2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; k = 0; lw = -1; l1 = -1;
    while (k < 40 && (lw < 0 || l1 < 0)) begin
      if (w_done && lw < 0) lw = k;
      if (o_done && l1 < 0) l1 = k;
      @(negedge clk);
      k++;
    end
    chk("c16_lat", lw, 32'd1);
    chk("c16_sum", {16'd0, w_sum}, 32'd0);
    chk("c16_cout", {31'd0, w_cout}, 32'd1);
    chk("c1_lat", l1, 32'd16);
    chk("c1_sum", {16'd0, o_sum}, 32'd0);
    chk("c1_cout", {31'd0, o_cout}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
